// File: rtl/dot_prod_pkg.sv
// Shared width helpers, saturation limits and FSM encoding for the dot_prod_mvm engine.
package dot_prod_pkg;

    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = value - 1;
        while (span > 0) begin
            result = result + 1;
            span   = span >> 1;
        end
        return result;
    endfunction

    function automatic int calcBitwidth(input int qn, input int qm);
        return qn + qm + 1;
    endfunction

    // Full-precision products plus log2(NCOL) growth, one spare bit for the bias preload.
    function automatic int calcAccBitwidth(input int bitwidth, input int ncol);
        return 2 * bitwidth + clog2(ncol) + 1;
    endfunction

    function automatic longint satMax(input int bitwidth);
        return (longint'(1) <<< (bitwidth - 1)) - 1;
    endfunction

    function automatic longint satMin(input int bitwidth);
        return -(longint'(1) <<< (bitwidth - 1));
    endfunction

    localparam int DEF_QN       = 6;
    localparam int DEF_QM       = 11;
    localparam int DEF_BITWIDTH = calcBitwidth(DEF_QN, DEF_QM);

    localparam logic [DEF_BITWIDTH-1:0] SAT_MAX = DEF_BITWIDTH'(satMax(DEF_BITWIDTH));
    localparam logic [DEF_BITWIDTH-1:0] SAT_MIN = DEF_BITWIDTH'(satMin(DEF_BITWIDTH));

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } stateType;

endpackage

// File: rtl/dot_prod_mvm_lane.sv
// One MAC lane: bias-preloadable accumulator, signed multiply-accumulate,
// and a round-half-up / saturate stage that registers the lane result.
module mac_lane
    import dot_prod_pkg::*;
#(
    parameter int QM           = 11,
    parameter int BITWIDTH     = 18,
    parameter int ACC_BITWIDTH = 40
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_clear,
    input  logic                i_biasEn,
    input  logic [BITWIDTH-1:0] i_bias,
    input  logic                i_macEn,
    input  logic [BITWIDTH-1:0] i_weight,
    input  logic [BITWIDTH-1:0] i_inputVal,
    input  logic                i_round,
    output logic [BITWIDTH-1:0] o_result,
    output logic                o_overflow
);

    localparam int PROD_BITWIDTH = 2 * BITWIDTH;
    localparam logic [BITWIDTH-1:0] SAT_HI = BITWIDTH'(satMax(BITWIDTH));
    localparam logic [BITWIDTH-1:0] SAT_LO = BITWIDTH'(satMin(BITWIDTH));
    localparam logic signed [ACC_BITWIDTH-1:0] ROUND_HALF = ACC_BITWIDTH'(longint'(1) <<< (QM - 1));

    logic signed [ACC_BITWIDTH-1:0]  r_acc;
    logic signed [PROD_BITWIDTH-1:0] w_product;
    logic signed [ACC_BITWIDTH-1:0]  w_productExt;
    logic signed [ACC_BITWIDTH-1:0]  w_biasExt;
    logic signed [ACC_BITWIDTH-1:0]  w_biased;
    logic signed [ACC_BITWIDTH-1:0]  w_shifted;
    logic [ACC_BITWIDTH-BITWIDTH:0]  w_upper;
    logic                            w_clip;
    logic [BITWIDTH-1:0]             w_saturated;
    logic [BITWIDTH-1:0]             r_result;
    logic                            r_overflow;

    assign w_product    = $signed(i_weight) * $signed(i_inputVal);
    assign w_productExt = {{(ACC_BITWIDTH-PROD_BITWIDTH){w_product[PROD_BITWIDTH-1]}}, w_product};
    assign w_biasExt    = {{(ACC_BITWIDTH-BITWIDTH-QM){i_bias[BITWIDTH-1]}}, i_bias, {QM{1'b0}}};

    // Result fits only if every bit above the output sign matches it.
    assign w_biased    = r_acc + ROUND_HALF;
    assign w_shifted   = w_biased >>> QM;
    assign w_upper     = w_shifted[ACC_BITWIDTH-1:BITWIDTH-1];
    assign w_clip      = !((&w_upper) || !(|w_upper));
    assign w_saturated = !w_clip ? w_shifted[BITWIDTH-1:0]
                                 : (w_shifted[ACC_BITWIDTH-1] ? SAT_LO : SAT_HI);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= i_biasEn ? w_biasExt : '0;
        end else if (i_macEn) begin
            r_acc <= r_acc + w_productExt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else if (i_round) begin
            r_result   <= w_saturated;
            r_overflow <= w_clip;
        end
    end

    assign o_result   = r_result;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/dot_prod_mvm.sv
// Signed fixed-point matrix-vector multiply: NROW MAC lanes fed one weight column
// per cycle from a registered-read weight RAM, with start/busy handshake.
module dot_prod_mvm
    import dot_prod_pkg::*;
#(
    parameter  int NROW          = 16,
    parameter  int NCOL          = 8,
    parameter  int QN            = 6,
    parameter  int QM            = 11,
    localparam int BITWIDTH      = calcBitwidth(QN, QM),
    localparam int ADDR_BITWIDTH = clog2(NCOL),
    localparam int ACC_BITWIDTH  = calcAccBitwidth(BITWIDTH, NCOL)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_BITWIDTH:0]   nCols,
    input  logic                     biasEn,
    input  logic [NROW*BITWIDTH-1:0] biasVec,
    input  logic [NROW*BITWIDTH-1:0] weightMemOutput,
    input  logic [BITWIDTH-1:0]      inputVec,
    output logic [ADDR_BITWIDTH-1:0] colAddressRead,
    output logic                     busy,
    output logic                     dataReady,
    output logic [NROW*BITWIDTH-1:0] outputVec,
    output logic [NROW-1:0]          overflow
);

    localparam logic [ADDR_BITWIDTH:0] NCOL_W = (ADDR_BITWIDTH+1)'(NCOL);

    stateType                 r_state;
    stateType                 w_nextState;
    logic [ADDR_BITWIDTH:0]   r_nCols;
    logic [ADDR_BITWIDTH:0]   w_nEff;
    logic [ADDR_BITWIDTH-1:0] r_colAddr;
    logic                     w_lastCol;
    logic                     w_accept;
    logic                     w_macEn;
    logic                     w_round;

    assign w_nEff    = (nCols == '0 || nCols > NCOL_W) ? NCOL_W : nCols;
    assign w_lastCol = ({1'b0, r_colAddr} == r_nCols - 1'b1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = FETCH;
            FETCH:   if (w_lastCol) w_nextState = DRAIN;
            DRAIN:   w_nextState = ROUND;
            ROUND:   w_nextState = DONE;
            DONE:    w_nextState = start ? FETCH : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Read data lags the address by one cycle, so the first FETCH cycle has nothing to add.
    always_comb begin
        w_accept  = (r_state == IDLE || r_state == DONE) && start;
        w_macEn   = (r_state == FETCH && r_colAddr != '0) || (r_state == DRAIN);
        w_round   = (r_state == ROUND);
        busy      = (r_state == FETCH) || (r_state == DRAIN) || (r_state == ROUND);
        dataReady = (r_state == DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_colAddr <= '0;
            r_nCols   <= '0;
        end else if (w_accept) begin
            r_colAddr <= '0;
            r_nCols   <= w_nEff;
        end else if (r_state == FETCH) begin
            r_colAddr <= r_colAddr + 1'b1;
        end
    end

    assign colAddressRead = r_colAddr;

    for (genvar row = 0; row < NROW; row++) begin : gLane
        mac_lane #(
            .QM           (QM),
            .BITWIDTH     (BITWIDTH),
            .ACC_BITWIDTH (ACC_BITWIDTH)
        ) u_lane (
            .clock      (clock),
            .reset      (reset),
            .i_clear    (w_accept),
            .i_biasEn   (biasEn),
            .i_bias     (biasVec[row*BITWIDTH +: BITWIDTH]),
            .i_macEn    (w_macEn),
            .i_weight   (weightMemOutput[row*BITWIDTH +: BITWIDTH]),
            .i_inputVal (inputVec),
            .i_round    (w_round),
            .o_result   (outputVec[row*BITWIDTH +: BITWIDTH]),
            .o_overflow (overflow[row])
        );
    end

endmodule

// File: tb/tb_dot_prod_mvm.sv
// Directed testbench for dot_prod_mvm with a registered-read weight RAM model
// and hand-computed Q6.11 expected results (1.0 = 2048).
module tb_dot_prod_mvm;

    localparam int NROW = 16;
    localparam int NCOL = 8;
    localparam int BW   = 18;
    localparam int ADDR = 3;
    localparam int VW   = NROW * BW;

    logic            clock;
    logic            reset;
    logic            start;
    logic [ADDR:0]   nCols;
    logic            biasEn;
    logic [VW-1:0]   biasVec;
    logic [VW-1:0]   weightMemOutput;
    logic [BW-1:0]   inputVec;
    logic [ADDR-1:0] colAddressRead;
    logic            busy;
    logic            dataReady;
    logic [VW-1:0]   outputVec;
    logic [NROW-1:0] overflow;

    logic [VW-1:0] wMem [NCOL];
    logic [BW-1:0] xMem [NCOL];

    int checkCount = 0;
    int passCount  = 0;

    dot_prod_mvm #(
        .NROW (NROW),
        .NCOL (NCOL),
        .QN   (6),
        .QM   (11)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .nCols           (nCols),
        .biasEn          (biasEn),
        .biasVec         (biasVec),
        .weightMemOutput (weightMemOutput),
        .inputVec        (inputVec),
        .colAddressRead  (colAddressRead),
        .busy            (busy),
        .dataReady       (dataReady),
        .outputVec       (outputVec),
        .overflow        (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case something upstream stalls the stimulus thread.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [VW-1:0] observed,
                               input logic [VW-1:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [VW-1:0] rep(input logic [BW-1:0] value);
        logic [VW-1:0] result;
        for (int i = 0; i < NROW; i++) result[i*BW +: BW] = value;
        return result;
    endfunction

    function automatic logic [VW-1:0] biasRamp();
        logic [VW-1:0] result;
        for (int i = 0; i < NROW; i++) result[i*BW +: BW] = BW'(i * 128);
        return result;
    endfunction

    task automatic fillColumns(input logic [BW-1:0] wVal, input logic [BW-1:0] xVal);
        for (int c = 0; c < NCOL; c++) begin
            wMem[c] = rep(wVal);
            xMem[c] = xVal;
        end
    endtask

    // The RAM captures the address at the edge and presents its data just after it.
    task automatic tick();
        logic [ADDR-1:0] addr;
        addr = colAddressRead;
        @(posedge clock);
        #1;
        weightMemOutput = wMem[addr];
        inputVec        = xMem[addr];
    endtask

    task automatic applyStimulus(input int n, input logic useBias);
        nCols  = (ADDR+1)'(n);
        biasEn = useBias;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int expLat,
                            input logic [VW-1:0] heldVal, input bit pokeStart);
        int cnt;
        bit busyOk;
        bit heldOk;
        bit seen;
        cnt    = 0;
        busyOk = 1'b1;
        heldOk = 1'b1;
        seen   = 1'b0;
        while (cnt < 40 && !seen) begin
            tick();
            cnt++;
            if (dataReady) begin
                seen = 1'b1;
            end else begin
                if (!busy) busyOk = 1'b0;
                if (outputVec !== heldVal) heldOk = 1'b0;
                start = pokeStart && (cnt == 2);
                if (start) nCols = 4'd2;
            end
        end
        start = 1'b0;
        checkOutput({tag, ".latency"}, VW'(cnt), VW'(expLat));
        checkOutput({tag, ".busyWhileRunning"}, VW'(busyOk), VW'(1));
        checkOutput({tag, ".heldWhileRunning"}, VW'(heldOk), VW'(1));
        checkOutput({tag, ".busyAtReady"}, VW'(busy), VW'(0));
    endtask

    task automatic checkResult(input string tag, input logic [VW-1:0] expVec,
                               input logic [NROW-1:0] expOvf);
        checkOutput({tag, ".outputVec"}, outputVec, expVec);
        checkOutput({tag, ".overflow"}, VW'(overflow), VW'(expOvf));
    endtask

    initial begin
        bit readySeen;

        reset           = 1'b0;
        start           = 1'b0;
        biasEn          = 1'b0;
        nCols           = '0;
        biasVec         = '0;
        weightMemOutput = '0;
        inputVec        = '0;
        fillColumns('0, '0);

        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset.outputVec", outputVec, '0);
        checkOutput("reset.overflow", VW'(overflow), '0);
        checkOutput("reset.dataReady", VW'(dataReady), '0);
        checkOutput("reset.busy", VW'(busy), '0);
        checkOutput("reset.colAddress", VW'(colAddressRead), '0);
        reset = 1'b1;
        tick();

        // 8 x (1.0 * 1.0) = 8.0
        fillColumns(18'd2048, 18'd2048);
        applyStimulus(8, 1'b0);
        waitDone("uniform8", 10, '0, 1'b0);
        checkResult("uniform8", rep(18'd16384), '0);
        tick();
        checkOutput("uniform8.pulseEnds", VW'(dataReady), '0);
        checkOutput("uniform8.resultHeld", outputVec, rep(18'd16384));

        // 1*1.0 + 2*0.5 + (-1)*3.0 = -1.0; unused columns would saturate if read
        fillColumns(18'h0F800, 18'h0F800);
        wMem[0] = rep(18'd2048); xMem[0] = 18'd2048;
        wMem[1] = rep(18'd1024); xMem[1] = 18'd4096;
        wMem[2] = rep(18'd6144); xMem[2] = 18'h3F800;
        applyStimulus(3, 1'b0);
        waitDone("perColumn3", 5, rep(18'd16384), 1'b0);
        checkResult("perColumn3", rep(18'h3F800), '0);

        // 4 x (-1.5 * 2.0) = -12.0
        fillColumns(18'h3F400, 18'd4096);
        applyStimulus(4, 1'b0);
        waitDone("negative4", 6, rep(18'h3F800), 1'b0);
        checkResult("negative4", rep(18'h3A000), '0);

        // nCols=0 means all 8 columns; 8 x 961.0 clips to the top
        fillColumns(18'h0F800, 18'h0F800);
        applyStimulus(0, 1'b0);
        waitDone("satPositive", 10, rep(18'h3A000), 1'b0);
        checkResult("satPositive", rep(18'h1FFFF), '1);

        // nCols=15 clamps to 8; negative product clips to the bottom
        fillColumns(18'h30800, 18'h0F800);
        applyStimulus(15, 1'b0);
        waitDone("satNegative", 10, rep(18'h1FFFF), 1'b0);
        checkResult("satNegative", rep(18'h20000), '1);

        fillColumns('0, 18'd2048);
        biasVec = rep(18'd1024);
        applyStimulus(8, 1'b1);
        waitDone("biasUniform", 10, rep(18'h20000), 1'b0);
        checkResult("biasUniform", rep(18'd1024), '0);

        biasVec = biasRamp();
        applyStimulus(2, 1'b1);
        waitDone("biasPerRow", 4, rep(18'd1024), 1'b0);
        checkResult("biasPerRow", biasRamp(), '0);

        // Single-column rounding around the half-LSB point, bias disabled
        fillColumns(18'd1, 18'd1024);
        applyStimulus(1, 1'b0);
        waitDone("roundHalfUp", 3, biasRamp(), 1'b0);
        checkResult("roundHalfUp", rep(18'd1), '0);

        fillColumns(18'd1, 18'd1023);
        applyStimulus(1, 1'b0);
        waitDone("roundBelowHalf", 3, rep(18'd1), 1'b0);
        checkResult("roundBelowHalf", rep(18'd0), '0);

        fillColumns(18'h3FFFF, 18'd1025);
        applyStimulus(1, 1'b0);
        waitDone("roundNegative", 3, rep(18'd0), 1'b0);
        checkResult("roundNegative", rep(18'h3FFFF), '0);

        // Back-to-back: second start issued in the DONE cycle, stray start while busy
        fillColumns(18'd2048, 18'd2048);
        applyStimulus(8, 1'b0);
        waitDone("b2bFirst", 10, rep(18'h3FFFF), 1'b0);
        checkResult("b2bFirst", rep(18'd16384), '0);
        fillColumns(18'h3F400, 18'd4096);
        applyStimulus(4, 1'b0);
        waitDone("b2bSecond", 6, rep(18'd16384), 1'b1);
        checkResult("b2bSecond", rep(18'h3A000), '0);

        // Abort in the middle of FETCH with an async reset
        fillColumns(18'd2048, 18'd2048);
        applyStimulus(8, 1'b0);
        repeat (4) tick();
        reset = 1'b0;
        #1;
        checkOutput("abort.outputVec", outputVec, '0);
        checkOutput("abort.overflow", VW'(overflow), '0);
        checkOutput("abort.busy", VW'(busy), '0);
        checkOutput("abort.dataReady", VW'(dataReady), '0);
        checkOutput("abort.colAddress", VW'(colAddressRead), '0);
        repeat (2) tick();
        reset = 1'b1;
        readySeen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (dataReady) readySeen = 1'b1;
        end
        checkOutput("abort.noDataReady", VW'(readySeen), '0);

        applyStimulus(8, 1'b0);
        waitDone("postReset", 10, '0, 1'b0);
        checkResult("postReset", rep(18'd16384), '0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
